// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and defaults for the VGA RAM prefetcher
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN,
    ST_DONE
  } req_state_t;

  localparam int          DEF_FRAME_WORDS = 153600;
  localparam logic [23:0] DEF_BASE_ADDR   = 24'h0;
  localparam int          PIX_W           = 8;

endpackage

// File: rtl/vga_word_fifo.sv
// rtl/vga_word_fifo.sv - synchronous word FIFO with occupancy count and flush
module vga_word_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = push && (r_count != (PTR_W+1)'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0);

  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_ram_prefetch.sv
// rtl/vga_ram_prefetch.sv - prefetches framebuffer words from RAM and unpacks pixels
module vga_ram_prefetch
  import vga_pkg::*;
#(
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 16,
  parameter int                FIFO_DEPTH  = 8,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pix_req,
  output logic [PIX_W-1:0]  pix_data,
  output logic              underflow
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

  req_state_t        r_state;
  req_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_byte_sel;
  logic [PIX_W-1:0]  r_pix_data;
  logic              r_underflow;

  logic [DATA_W-1:0] w_fifo_rdata;
  logic [FC_W-1:0]   w_fifo_count;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [FC_W-1:0]   w_fill_after;

  assign mem_req   = (r_state == ST_REQ) || (r_state == ST_DRAIN);
  assign mem_addr  = r_addr;
  assign pix_data  = r_pix_data;
  assign underflow = r_underflow;

  // A flush in the same cycle as an ack drops the word instead of storing it.
  assign w_push       = (r_state == ST_REQ) && mem_ack && !frame_start;
  assign w_pop        = pix_req && !frame_start && !w_fifo_empty && r_byte_sel;
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_fill_after = w_fifo_count + FC_W'(1) - FC_W'(w_pop);

  vga_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (w_push),
    .wdata (mem_rdata),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .count (w_fifo_count),
    .empty (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      // An open RAM transaction must complete before the new frame fetches.
      if (mem_req && !mem_ack) w_state_nxt = ST_DRAIN;
      else                     w_state_nxt = ST_REQ;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((w_fifo_count < FC_W'(FIFO_DEPTH)) && (r_cnt < CNT_W'(FRAME_WORDS)))
            w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (mem_ack) begin
            if ((w_fill_after < FC_W'(FIFO_DEPTH)) && (w_cnt_inc < CNT_W'(FRAME_WORDS)))
              w_state_nxt = ST_REQ;
            else if (w_cnt_inc == CNT_W'(FRAME_WORDS))
              w_state_nxt = ST_DONE;
            else
              w_state_nxt = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (mem_ack) w_state_nxt = ST_IDLE;
        end
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= BASE_ADDR;
      r_cnt       <= '0;
      r_byte_sel  <= 1'b0;
      r_pix_data  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (frame_start) begin
        r_addr <= BASE_ADDR;
        r_cnt  <= '0;
      end else if (w_push) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= w_cnt_inc;
      end

      // pix_data holds across a flush; a coincident pix_req counts against the new frame.
      if (frame_start) begin
        r_byte_sel  <= 1'b0;
        r_underflow <= pix_req;
      end else if (pix_req) begin
        if (w_fifo_empty) begin
          r_pix_data  <= '0;
          r_underflow <= 1'b1;
        end else begin
          r_pix_data <= r_byte_sel ? w_fifo_rdata[2*PIX_W-1:PIX_W] : w_fifo_rdata[PIX_W-1:0];
          r_byte_sel <= ~r_byte_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_ram_prefetch.sv
// tb/tb_vga_ram_prefetch.sv - directed self-checking bench for vga_ram_prefetch
module tb_vga_ram_prefetch;

  logic        clk;
  logic        rst_n;

  logic        s_frame_start, s_mem_req, s_mem_ack, s_pix_req, s_underflow;
  logic [23:0] s_mem_addr;
  logic [15:0] s_mem_rdata;
  logic [7:0]  s_pix_data;

  logic        b_frame_start, b_mem_req, b_mem_ack, b_pix_req, b_underflow;
  logic [23:0] b_mem_addr;
  logic [15:0] b_mem_rdata;
  logic [7:0]  b_pix_data;

  logic [23:0] s_log[$];
  int          b_ack_cnt;
  logic [23:0] b_last_addr;
  logic        b_en;
  int          b_delay;
  int          b_wc;

  int n_cmp;
  int n_bad;

  vga_ram_prefetch #(.FRAME_WORDS(4)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(s_mem_ack), .mem_rdata(s_mem_rdata),
    .pix_req(s_pix_req), .pix_data(s_pix_data), .underflow(s_underflow)
  );

  vga_ram_prefetch #(.FRAME_WORDS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(b_frame_start),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .pix_req(b_pix_req), .pix_data(b_pix_data), .underflow(b_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word_of(input logic [23:0] a);
    if (a == 24'd0)      return 16'hBBAA;
    else if (a == 24'd1) return 16'hDDCC;
    else                 return {~a[7:0], a[7:0]};
  endfunction

  // Zero-wait RAM for the small instance.
  initial begin
    s_mem_ack   = 1'b0;
    s_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) s_mem_ack = 1'b0;
      else if (s_mem_ack) s_mem_ack = 1'b0;
      else if (s_mem_req) begin
        s_mem_ack   = 1'b1;
        s_mem_rdata = word_of(s_mem_addr);
        s_log.push_back(s_mem_addr);
      end
    end
  end

  // RAM with enable and programmable wait for the main instance.
  initial begin
    b_mem_ack   = 1'b0;
    b_mem_rdata = '0;
    b_ack_cnt   = 0;
    b_last_addr = '0;
    b_wc        = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_mem_ack = 1'b0;
        b_wc      = 0;
      end else if (b_mem_ack) b_mem_ack = 1'b0;
      else if (b_mem_req && b_en) begin
        if (b_wc >= b_delay) begin
          b_mem_ack   = 1'b1;
          b_mem_rdata = word_of(b_mem_addr);
          b_last_addr = b_mem_addr;
          b_ack_cnt   = b_ack_cnt + 1;
          b_wc        = 0;
        end else b_wc = b_wc + 1;
      end else b_wc = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (s_mem_req !== 1'b0)      begin n_bad++; $display("FAIL reset_s_req: got %b want 0", s_mem_req); end
    n_cmp++; if (b_mem_req !== 1'b0)      begin n_bad++; $display("FAIL reset_b_req: got %b want 0", b_mem_req); end
    n_cmp++; if (b_mem_addr !== 24'h0)    begin n_bad++; $display("FAIL reset_addr: got %h want 000000", b_mem_addr); end
    n_cmp++; if (b_pix_data !== 8'h00)    begin n_bad++; $display("FAIL reset_pix: got %h want 00", b_pix_data); end
    n_cmp++; if (b_underflow !== 1'b0)    begin n_bad++; $display("FAIL reset_uf: got %b want 0", b_underflow); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_frame_done;
    logic seen_req;
    repeat (30) tick();
    n_cmp++; if (s_log.size() != 4) begin n_bad++; $display("FAIL done_count: got %0d want 4", s_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < s_log.size()) begin
        n_cmp++;
        if (s_log[i] !== 24'(i)) begin n_bad++; $display("FAIL done_addr%0d: got %h want %h", i, s_log[i], 24'(i)); end
      end
    end
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (s_mem_req !== 1'b0) seen_req = 1'b1;
      tick();
    end
    n_cmp++; if (seen_req) begin n_bad++; $display("FAIL done_hold: got mem_req=1 want 0 in DONE"); end
  endtask

  task automatic test_pixel_unpack;
    logic [7:0] exp_pix [4];
    exp_pix = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    s_pix_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) s_pix_req = 1'b0;
      n_cmp++;
      if (s_pix_data !== exp_pix[i]) begin n_bad++; $display("FAIL unpack%0d: got %h want %h", i, s_pix_data, exp_pix[i]); end
    end
    n_cmp++; if (s_underflow !== 1'b0) begin n_bad++; $display("FAIL unpack_uf: got %b want 0", s_underflow); end
  endtask

  task automatic test_frame_restart;
    s_frame_start = 1'b1;
    tick();
    s_frame_start = 1'b0;
    n_cmp++; if (s_mem_req !== 1'b1)   begin n_bad++; $display("FAIL restart_req: got %b want 1", s_mem_req); end
    n_cmp++; if (s_mem_addr !== 24'h0) begin n_bad++; $display("FAIL restart_addr: got %h want 000000", s_mem_addr); end
  endtask

  task automatic test_fifo_full;
    n_cmp++; if (b_ack_cnt != 8)    begin n_bad++; $display("FAIL full_acks: got %0d want 8", b_ack_cnt); end
    n_cmp++; if (b_mem_req !== 1'b0) begin n_bad++; $display("FAIL full_req: got %b want 0", b_mem_req); end
    b_pix_req = 1'b1;
    tick();
    tick();
    b_pix_req = 1'b0;
    n_cmp++; if (b_pix_data !== 8'hBB) begin n_bad++; $display("FAIL full_pix: got %h want BB", b_pix_data); end
    repeat (20) tick();
    n_cmp++; if (b_ack_cnt != 9)        begin n_bad++; $display("FAIL refill_acks: got %0d want 9", b_ack_cnt); end
    n_cmp++; if (b_last_addr !== 24'd8) begin n_bad++; $display("FAIL refill_addr: got %h want 000008", b_last_addr); end
    n_cmp++; if (b_mem_req !== 1'b0)    begin n_bad++; $display("FAIL refill_req: got %b want 0", b_mem_req); end
  endtask

  task automatic test_underflow;
    b_en = 1'b0;
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    n_cmp++; if (b_pix_data !== 8'hBB) begin n_bad++; $display("FAIL flush_hold_pix: got %h want BB", b_pix_data); end
    n_cmp++; if (b_mem_req !== 1'b1)   begin n_bad++; $display("FAIL flush_req: got %b want 1", b_mem_req); end
    b_pix_req = 1'b1;
    tick();
    b_pix_req = 1'b0;
    n_cmp++; if (b_pix_data !== 8'h00) begin n_bad++; $display("FAIL uf_pix: got %h want 00", b_pix_data); end
    n_cmp++; if (b_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set: got %b want 1", b_underflow); end
    repeat (3) tick();
    n_cmp++; if (b_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky: got %b want 1", b_underflow); end
    b_frame_start = 1'b1;
    tick();
    n_cmp++; if (b_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clear: got %b want 0", b_underflow); end
    b_pix_req = 1'b1;
    tick();
    b_frame_start = 1'b0;
    b_pix_req     = 1'b0;
    n_cmp++; if (b_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_fs_pix: got %b want 1", b_underflow); end
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    n_cmp++; if (b_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clear2: got %b want 0", b_underflow); end
    n_cmp++; if (b_mem_req !== 1'b1)   begin n_bad++; $display("FAIL drain_hold: got %b want 1", b_mem_req); end
  endtask

  task automatic read_pixels(input int n, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_pix [4];
    exp_pix = '{e0, e1, e2, e3};
    b_pix_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == n - 1) b_pix_req = 1'b0;
      n_cmp++;
      if (b_pix_data !== exp_pix[i]) begin n_bad++; $display("FAIL read%0d: got %h want %h", i, b_pix_data, exp_pix[i]); end
    end
  endtask

  task automatic wait_req(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (b_mem_req === 1'b1) begin got = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL %s_timeout: got no mem_req want mem_req=1", tag); end
  endtask

  task automatic test_drain;
    int  start;
    bit  held;
    b_en    = 1'b1;
    b_delay = 0;
    repeat (40) tick();
    b_delay = 5;
    read_pixels(2, 8'hAA, 8'hBB, 8'h00, 8'h00);
    wait_req("drain_pre");
    n_cmp++; if (b_mem_addr !== 24'd8) begin n_bad++; $display("FAIL drain_pre_addr: got %h want 000008", b_mem_addr); end
    start = b_ack_cnt;
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (b_ack_cnt != start) break;
      if (b_mem_req !== 1'b1) held = 1'b0;
      tick();
    end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL drain_req_held: got mem_req=0 want 1 until ack"); end
    n_cmp++; if (b_ack_cnt != start + 1) begin n_bad++; $display("FAIL drain_ack: got %0d want %0d", b_ack_cnt, start + 1); end
    wait_req("drain_post");
    n_cmp++; if (b_mem_addr !== 24'h0) begin n_bad++; $display("FAIL drain_next_addr: got %h want 000000", b_mem_addr); end
    b_delay = 0;
    repeat (40) tick();
    read_pixels(4, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
  endtask

  task automatic test_async_reset;
    b_delay = 5;
    read_pixels(2, 8'h02, 8'hFD, 8'h00, 8'h00);
    wait_req("rst_pre");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (b_mem_req !== 1'b0)   begin n_bad++; $display("FAIL arst_req: got %b want 0", b_mem_req); end
    n_cmp++; if (b_mem_addr !== 24'h0) begin n_bad++; $display("FAIL arst_addr: got %h want 000000", b_mem_addr); end
    n_cmp++; if (b_pix_data !== 8'h00) begin n_bad++; $display("FAIL arst_pix: got %h want 00", b_pix_data); end
    n_cmp++; if (b_underflow !== 1'b0) begin n_bad++; $display("FAIL arst_uf: got %b want 0", b_underflow); end
    n_cmp++; if (s_pix_data !== 8'h00) begin n_bad++; $display("FAIL arst_s_pix: got %h want 00", s_pix_data); end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b1;
    s_frame_start = 1'b0;
    s_pix_req     = 1'b0;
    b_frame_start = 1'b0;
    b_pix_req     = 1'b0;
    b_en          = 1'b1;
    b_delay       = 0;
    #1 rst_n = 1'b0;
    test_reset();
    test_frame_done();
    test_pixel_unpack();
    test_frame_restart();
    test_fifo_full();
    test_underflow();
    test_drain();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
